// File: rtl/sw_irq_pkg.sv
// Shared types and helpers for the switch/button debounce and interrupt-pending block.
package sw_irq_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        WAIT_HI,
        STABLE_HI,
        WAIT_LO
    } db_state_t;

    // The counter never holds more than cycles-1, so $clog2 is enough; keep at least one bit.
    function automatic int db_cnt_w(int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchronizer followed by a debounce FSM with a stability counter.
//
// state     | meaning
// STABLE_LO | debounced level is 0, input agrees
// WAIT_HI   | input went high, counting consecutive high samples
// STABLE_HI | debounced level is 1, input agrees
// WAIT_LO   | input went low, counting consecutive low samples
module debounce_channel
    import sw_irq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = db_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic s1, s2;
    db_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1    <= sw_in;
            s2    <= s1;
            state <= state_nx;
            cnt   <= cnt_nx;
            if (rise) level <= 1'b1;
            else if (fall) level <= 1'b0;
        end
    end

    // rise/fall are acceptance strobes for this edge; the top registers them.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rise     = 1'b0;
        fall     = 1'b0;
        case (state)
            STABLE_LO: begin
                if (s2) begin
                    state_nx = WAIT_HI;
                    cnt_nx   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!s2) begin
                    state_nx = STABLE_LO;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = STABLE_HI;
                    cnt_nx   = '0;
                    rise     = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s2) begin
                    state_nx = WAIT_LO;
                    cnt_nx   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (s2) begin
                    state_nx = STABLE_HI;
                    cnt_nx   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = STABLE_LO;
                    cnt_nx   = '0;
                    fall     = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nx = STABLE_LO;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: rtl/sw_irq_debounce.sv
// N debounced switch channels with edge pulses and sticky, CLIC-clearable pending bits.
module sw_irq_debounce
    import sw_irq_pkg::*;
#(
    parameter int N_IN            = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_IN-1:0] sw_in,
    input  logic [N_IN-1:0] rise_en,
    input  logic [N_IN-1:0] fall_en,
    input  logic [N_IN-1:0] irq_clear,
    output logic [N_IN-1:0] level_out,
    output logic [N_IN-1:0] edge_pulse,
    output logic [N_IN-1:0] irq_pend
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("sw_irq_debounce: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [N_IN-1:0] rise, fall, level;

    for (genvar i = 0; i < N_IN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .sw_in (sw_in[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

    assign level_out = level;

    // Set is ORed in after the clear so an event accepted alongside a clear is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_pulse <= '0;
            irq_pend   <= '0;
        end else begin
            edge_pulse <= rise | fall;
            irq_pend   <= (irq_pend & ~irq_clear) | (rise & rise_en) | (fall & fall_en);
        end
    end

endmodule
